die_wrapper_boundary_reg: RTL and testbench
===========================================

Name: die_wrapper_boundary_reg

Overview:
- Parametrised next-generation die wrapper boundary register (WBR) for the SiP test path.
- Provides NUM_IN input-side cells and NUM_OUT output-side cells, each with a shift/capture stage and an update stage.
- Supports the EXTEST, SAMPLE/PRELOAD, INTEST and CLAMP instructions, with a programmable safe update value and a shift-length counter.
- Sits between the TAP controller/IR decode and the die pad/core boundary; its TDO feeds the top-level TDO mux.

Parameters:
- NUM_IN, 4, number of input-side cells (pad -> core); must be >= 1.
- NUM_OUT, 4, number of output-side cells (core -> pad); must be >= 1.
- CNT_W, 8, shift counter width.
- UPD_RST, {NUM_IN+NUM_OUT}'h0, update-stage value on reset and in TEST_LOGIC_RESET.
- ST_TLR, 4'd0, tap_state code for TEST_LOGIC_RESET.
- ST_CAPTURE_DR, 4'd3, tap_state code for CAPTURE_DR.
- ST_SHIFT_DR, 4'd4, tap_state code for SHIFT_DR.
- ST_UPDATE_DR, 4'd8, tap_state code for UPDATE_DR.
- IR_EXTEST, 4'h0, instruction code for EXTEST.
- IR_SAMPLE, 4'h1, instruction code for SAMPLE/PRELOAD.
- IR_INTEST, 4'h2, instruction code for INTEST.
- IR_CLAMP, 4'h3, instruction code for CLAMP.

Ports:
- TCK  input  1  test clock; all state updates on posedge.
- TRST  input  1  asynchronous, active-high reset.
- TDI  input  1  serial scan in.
- tap_state  input  4  current TAP controller state.
- IR  input  4  current instruction register value.
- pad_in  input  NUM_IN  values arriving from the die pads.
- core_out  input  NUM_OUT  functional outputs from the core.
- core_in  output  NUM_IN  values driven into the core.
- pad_out  output  NUM_OUT  values driven to the pads.
- wrapper_tdo  output  1  serial scan out; equals chain[0].
- wbr_sel  output  1  high when IR selects the WBR (EXTEST, SAMPLE or INTEST).
- shift_cnt  output  CNT_W  number of SHIFT_DR cycles since the last capture.

Behaviour:
- Let N = NUM_IN + NUM_OUT.
- Internal state: chain[N-1:0] (shift stage), upd[N-1:0] (update stage).
- Bits [NUM_IN-1:0] are input cells; bits [N-1:NUM_IN] are output cells.
- Reset (TRST=1, asynchronous): chain=0, upd=UPD_RST, shift_cnt=0, wrapper_tdo=0. Reset takes effect immediately, including mid-shift.
- sel = (IR==IR_EXTEST) | (IR==IR_SAMPLE) | (IR==IR_INTEST). wbr_sel = sel, combinational.
- Per-posedge operation; tap_state holds one value, so only one operation occurs per cycle:
  - ST_TLR: upd <= UPD_RST. chain holds. Applies regardless of IR.
  - ST_CAPTURE_DR with sel: chain[NUM_IN-1:0] <= pad_in; chain[N-1:NUM_IN] <= core_out; shift_cnt <= 0.
  - ST_SHIFT_DR with sel: chain <= {TDI, chain[N-1:1]}; shift_cnt increments, saturating at 2^CNT_W-1.
  - ST_UPDATE_DR with sel: upd <= chain.
  - Any other state, or sel=0 (including CLAMP and unknown IR): chain, upd and shift_cnt hold.
- Output muxes (combinational on the current IR):
  - pad_out = upd[N-1:NUM_IN] when IR is EXTEST or CLAMP; otherwise core_out.
  - core_in = upd[NUM_IN-1:0] when IR==INTEST; otherwise pad_in.
- SAMPLE/PRELOAD never drives the boundary. A value updated under SAMPLE appears at the outputs as soon as IR changes to EXTEST or INTEST, with no further update cycle.
- An IR change mid-shift is not an error: each cycle is gated by that cycle's IR. Chain contents persist across instructions.
- Latency: a TDI bit appears on wrapper_tdo after N SHIFT_DR edges.

Test Plan:
- Reset: TRST=1 with IR=EXTEST, core_out=0x5 -> chain=0x00, upd=0x00, wrapper_tdo=0, shift_cnt=0, pad_out=0x0, core_in=pad_in.
- EXTEST capture/shift/update:
  - Capture with pad_in=0xA, core_out=0x5 -> chain=0x5A.
  - 8 SHIFT_DR cycles with TDI = 0xC3 LSB-first -> wrapper_tdo sequence 0,1,0,1,1,0,1,0; chain=0xC3; shift_cnt=8.
  - UPDATE_DR -> pad_out=0xC, core_in=pad_in.
- INTEST: shift 0x96 then update -> core_in=0x6, pad_out=core_out.
- SAMPLE preload then switch:
  - Under SAMPLE, shift and update 0x3C -> pad_out still equals core_out.
  - Change IR to EXTEST with no new update -> pad_out=0x3.
- CLAMP: with upd=0xC3, drive CAPTURE_DR, SHIFT_DR and UPDATE_DR cycles -> chain, upd and shift_cnt unchanged; wbr_sel=0; pad_out=0xC.
- TLR and mid-shift reset:
  - ST_TLR -> upd=UPD_RST and pad_out=0x0 under EXTEST.
  - TRST pulse after 3 shift cycles -> chain=0 immediately; shift_cnt=0.
  - Set CNT_W=2 and run 5 shifts -> shift_cnt saturates at 3.

Source files
------------

// File: rtl/die_wrapper_boundary_reg_if.sv
// Boundary-register signal bundle: TAP/IR-side controls, pad/core boundary
// nets and the scan/status outputs. master = TAP + boundary environment,
// slave = the wrapper boundary register itself.
interface die_wrapper_boundary_reg_if #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int CNT_W   = 8
);
    logic               TDI;
    logic [3:0]         tap_state;
    logic [3:0]         IR;
    logic [NUM_IN-1:0]  pad_in;
    logic [NUM_OUT-1:0] core_out;
    logic [NUM_IN-1:0]  core_in;
    logic [NUM_OUT-1:0] pad_out;
    logic               wrapper_tdo;
    logic               wbr_sel;
    logic [CNT_W-1:0]   shift_cnt;

    modport master (
        output TDI, tap_state, IR, pad_in, core_out,
        input  core_in, pad_out, wrapper_tdo, wbr_sel, shift_cnt
    );

    modport slave (
        input  TDI, tap_state, IR, pad_in, core_out,
        output core_in, pad_out, wrapper_tdo, wbr_sel, shift_cnt
    );
endinterface

// File: rtl/die_wrapper_boundary_reg.sv
// Die wrapper boundary register: NUM_IN pad->core cells at the LSB end of the
// chain, NUM_OUT core->pad cells above them. Each cell has a shift/capture
// flop and an update flop; the instruction selects which side the update
// stage drives.

// One boundary cell: shift/capture stage plus update stage.
module wbr_cell #(
    parameter logic UPD_RST_BIT = 1'b0
) (
    input  logic TCK,
    input  logic TRST,
    input  logic capture_en,
    input  logic shift_en,
    input  logic update_en,
    input  logic tlr,
    input  logic cap_d,
    input  logic shift_d,
    output logic chain_q,
    output logic upd_q
);
    // Shift/capture stage; capture and shift are mutually exclusive by tap_state.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST)            chain_q <= 1'b0;
        else if (capture_en) chain_q <= cap_d;
        else if (shift_en)   chain_q <= shift_d;
    end

    // Update stage; TEST_LOGIC_RESET restores the safe value whatever the IR.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST)           upd_q <= UPD_RST_BIT;
        else if (tlr)       upd_q <= UPD_RST_BIT;
        else if (update_en) upd_q <= chain_q;
    end
endmodule

module die_wrapper_boundary_reg #(
    parameter int                           NUM_IN        = 4,
    parameter int                           NUM_OUT       = 4,
    parameter int                           CNT_W         = 8,
    parameter logic [NUM_IN+NUM_OUT-1:0]    UPD_RST       = '0,
    parameter logic [3:0]                   ST_TLR        = 4'd0,
    parameter logic [3:0]                   ST_CAPTURE_DR = 4'd3,
    parameter logic [3:0]                   ST_SHIFT_DR   = 4'd4,
    parameter logic [3:0]                   ST_UPDATE_DR  = 4'd8,
    parameter logic [3:0]                   IR_EXTEST     = 4'h0,
    parameter logic [3:0]                   IR_SAMPLE     = 4'h1,
    parameter logic [3:0]                   IR_INTEST     = 4'h2,
    parameter logic [3:0]                   IR_CLAMP      = 4'h3
) (
    input  logic                       TCK,
    input  logic                       TRST,
    die_wrapper_boundary_reg_if.slave  bus
);
    localparam int N = NUM_IN + NUM_OUT;

    logic             sel;
    logic             capture_en, shift_en, update_en, tlr;
    logic [N-1:0]     chain, upd;
    logic [N-1:0]     cap_vec, shift_vec;
    logic [CNT_W-1:0] cnt;

    // CLAMP and unknown codes leave the chain untouched.
    assign sel        = (bus.IR == IR_EXTEST) | (bus.IR == IR_SAMPLE) | (bus.IR == IR_INTEST);
    assign capture_en = sel && (bus.tap_state == ST_CAPTURE_DR);
    assign shift_en   = sel && (bus.tap_state == ST_SHIFT_DR);
    assign update_en  = sel && (bus.tap_state == ST_UPDATE_DR);
    assign tlr        = (bus.tap_state == ST_TLR);

    // Output cells capture what the core drives; input cells capture the pads.
    assign cap_vec   = {bus.core_out, bus.pad_in};
    // Shift toward bit 0: TDI enters the top cell, chain[0] leaves on TDO.
    assign shift_vec = {bus.TDI, chain[N-1:1]};

    for (genvar i = 0; i < N; i++) begin : g_cell
        wbr_cell #(.UPD_RST_BIT(UPD_RST[i])) u_cell (
            .TCK        (TCK),
            .TRST       (TRST),
            .capture_en (capture_en),
            .shift_en   (shift_en),
            .update_en  (update_en),
            .tlr        (tlr),
            .cap_d      (cap_vec[i]),
            .shift_d    (shift_vec[i]),
            .chain_q    (chain[i]),
            .upd_q      (upd[i])
        );
    end

    // Shift-length counter: cleared on capture, saturates instead of wrapping.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST)                       cnt <= '0;
        else if (capture_en)            cnt <= '0;
        else if (shift_en && cnt != '1) cnt <= cnt + 1'b1;
    end

    // Boundary muxes follow the live IR, so an update done under SAMPLE shows
    // up as soon as IR moves to EXTEST/INTEST.
    assign bus.pad_out     = ((bus.IR == IR_EXTEST) || (bus.IR == IR_CLAMP)) ? upd[N-1:NUM_IN] : bus.core_out;
    assign bus.core_in     = (bus.IR == IR_INTEST) ? upd[NUM_IN-1:0] : bus.pad_in;
    assign bus.wrapper_tdo = chain[0];
    assign bus.wbr_sel     = sel;
    assign bus.shift_cnt   = cnt;
endmodule

// File: tb/tb_die_wrapper_boundary_reg.sv
// Bench for the die wrapper boundary register: scoreboarded TDO stream plus
// per-scenario boundary/counter checks against a small behavioural model.
module tb_die_wrapper_boundary_reg;
    localparam logic [3:0] ST_TLR  = 4'd0;
    localparam logic [3:0] ST_IDLE = 4'd1;
    localparam logic [3:0] ST_CAP  = 4'd3;
    localparam logic [3:0] ST_SH   = 4'd4;
    localparam logic [3:0] ST_UPD  = 4'd8;
    localparam logic [3:0] IR_EX   = 4'h0;
    localparam logic [3:0] IR_SA   = 4'h1;
    localparam logic [3:0] IR_IN   = 4'h2;
    localparam logic [3:0] IR_CL   = 4'h3;

    logic TCK = 1'b0;
    logic TRST;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] m_chain, m_upd;
    int         m_cnt;
    logic       tdo_q[$];

    always #5 TCK = ~TCK;

    die_wrapper_boundary_reg_if #(.NUM_IN(4), .NUM_OUT(4), .CNT_W(8)) bus ();
    die_wrapper_boundary_reg_if #(.NUM_IN(4), .NUM_OUT(4), .CNT_W(2)) bus2 ();

    die_wrapper_boundary_reg #(.NUM_IN(4), .NUM_OUT(4), .CNT_W(8)) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .bus  (bus)
    );

    die_wrapper_boundary_reg #(.NUM_IN(4), .NUM_OUT(4), .CNT_W(2)) dut2 (
        .TCK  (TCK),
        .TRST (TRST),
        .bus  (bus2)
    );

    // Advance one TCK cycle and update the reference model of the main DUT.
    task automatic step();
        logic       sel;
        logic [3:0] st;
        logic [7:0] cap;
        logic       tdi;
        sel = (bus.IR == IR_EX) || (bus.IR == IR_SA) || (bus.IR == IR_IN);
        st  = bus.tap_state;
        cap = {bus.core_out, bus.pad_in};
        tdi = bus.TDI;
        @(posedge TCK);
        if (st == ST_TLR) m_upd = 8'h00;
        else if (sel && st == ST_CAP) begin
            m_chain = cap;
            m_cnt   = 0;
        end else if (sel && st == ST_SH) begin
            m_chain = {tdi, m_chain[7:1]};
            if (m_cnt < 255) m_cnt++;
        end else if (sel && st == ST_UPD) m_upd = m_chain;
        @(negedge TCK);
        bus.tap_state = ST_IDLE;
    endtask

    task automatic test_reset();
        TRST = 1'b1;
        bus.IR = IR_EX; bus.core_out = 4'h5; bus.pad_in = 4'h9;
        #1;
        checks++; if (bus.wrapper_tdo !== 1'b0) begin failures++; $display("FAIL reset_tdo got=%b exp=0", bus.wrapper_tdo); end
        checks++; if (bus.shift_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.shift_cnt); end
        checks++; if (bus.pad_out !== 4'h0) begin failures++; $display("FAIL reset_pad_out got=%h exp=0", bus.pad_out); end
        checks++; if (bus.core_in !== 4'h9) begin failures++; $display("FAIL reset_core_in got=%h exp=9", bus.core_in); end
        checks++; if (bus.wbr_sel !== 1'b1) begin failures++; $display("FAIL reset_wbr_sel got=%b exp=1", bus.wbr_sel); end
        m_chain = 8'h00; m_upd = 8'h00; m_cnt = 0;
        @(negedge TCK);
        TRST = 1'b0;
    endtask

    // Shift one byte in LSB-first; the outgoing TDO stream is scoreboarded.
    task automatic test_shift_byte(input string name, input logic [7:0] din);
        logic exp;
        for (int i = 0; i < 8; i++) begin
            bus.TDI = din[i];
            bus.tap_state = ST_SH;
            tdo_q.push_back(m_chain[0]);
            exp = tdo_q.pop_front();
            checks++;
            if (bus.wrapper_tdo !== exp) begin
                failures++;
                $display("FAIL %s_tdo[%0d] got=%b exp=%b", name, i, bus.wrapper_tdo, exp);
            end
            step();
        end
    endtask

    task automatic test_extest();
        bus.IR = IR_EX; bus.pad_in = 4'hA; bus.core_out = 4'h5;
        bus.tap_state = ST_CAP; step();
        checks++; if (m_chain !== 8'h5A) begin failures++; $display("FAIL extest_model_capture got=%h exp=5a", m_chain); end
        // Capture of 0x5A must come out as 0,1,0,1,1,0,1,0.
        test_shift_byte("extest", 8'hC3);
        checks++; if (bus.shift_cnt !== 8'd8) begin failures++; $display("FAIL extest_cnt got=%0d exp=8", bus.shift_cnt); end
        checks++; if (bus.wrapper_tdo !== 1'b1) begin failures++; $display("FAIL extest_tdo_after got=%b exp=1", bus.wrapper_tdo); end
        bus.tap_state = ST_UPD; step();
        checks++; if (bus.pad_out !== 4'hC) begin failures++; $display("FAIL extest_pad_out got=%h exp=c", bus.pad_out); end
        checks++; if (bus.core_in !== 4'hA) begin failures++; $display("FAIL extest_core_in got=%h exp=a", bus.core_in); end
    endtask

    task automatic test_intest();
        bus.IR = IR_IN;
        test_shift_byte("intest", 8'h96);
        bus.tap_state = ST_UPD; step();
        checks++; if (bus.core_in !== 4'h6) begin failures++; $display("FAIL intest_core_in got=%h exp=6", bus.core_in); end
        checks++; if (bus.pad_out !== 4'h5) begin failures++; $display("FAIL intest_pad_out got=%h exp=5", bus.pad_out); end
    endtask

    task automatic test_sample_preload();
        bus.IR = IR_SA;
        test_shift_byte("sample", 8'h3C);
        bus.tap_state = ST_UPD; step();
        checks++; if (bus.pad_out !== 4'h5) begin failures++; $display("FAIL sample_pad_out got=%h exp=5", bus.pad_out); end
        checks++; if (bus.core_in !== 4'hA) begin failures++; $display("FAIL sample_core_in got=%h exp=a", bus.core_in); end
        checks++; if (bus.wbr_sel !== 1'b1) begin failures++; $display("FAIL sample_wbr_sel got=%b exp=1", bus.wbr_sel); end
        bus.IR = IR_EX; #1;
        checks++; if (bus.pad_out !== 4'h3) begin failures++; $display("FAIL preload_extest_pad_out got=%h exp=3", bus.pad_out); end
        bus.IR = IR_IN; #1;
        checks++; if (bus.core_in !== 4'hC) begin failures++; $display("FAIL preload_intest_core_in got=%h exp=c", bus.core_in); end
    endtask

    task automatic test_clamp();
        // Load upd=0xC3 under EXTEST without a fresh capture.
        bus.IR = IR_EX;
        test_shift_byte("clamp_load", 8'hC3);
        bus.tap_state = ST_UPD; step();
        bus.IR = IR_CL; bus.pad_in = 4'hF; bus.core_out = 4'h0; #1;
        checks++; if (bus.wbr_sel !== 1'b0) begin failures++; $display("FAIL clamp_wbr_sel got=%b exp=0", bus.wbr_sel); end
        bus.tap_state = ST_CAP; step();
        for (int i = 0; i < 3; i++) begin
            bus.TDI = 1'b0; bus.tap_state = ST_SH; step();
        end
        bus.tap_state = ST_UPD; step();
        checks++; if (bus.shift_cnt !== m_cnt[7:0]) begin failures++; $display("FAIL clamp_cnt got=%0d exp=%0d", bus.shift_cnt, m_cnt); end
        checks++; if (bus.pad_out !== 4'hC) begin failures++; $display("FAIL clamp_pad_out got=%h exp=c", bus.pad_out); end
        checks++; if (bus.core_in !== 4'hF) begin failures++; $display("FAIL clamp_core_in got=%h exp=f", bus.core_in); end
        checks++; if (bus.wrapper_tdo !== 1'b1) begin failures++; $display("FAIL clamp_tdo got=%b exp=1", bus.wrapper_tdo); end
        bus.IR = IR_EX; #1;
        checks++; if (bus.pad_out !== m_upd[7:4]) begin failures++; $display("FAIL clamp_upd_held got=%h exp=%h", bus.pad_out, m_upd[7:4]); end
        // Chain must still be 0xC3 after the ignored CLAMP operations.
        test_shift_byte("clamp_chain", 8'h00);
    endtask

    task automatic test_tlr();
        bus.IR = IR_CL; bus.tap_state = ST_TLR; step();
        checks++; if (bus.pad_out !== 4'h0) begin failures++; $display("FAIL tlr_clamp_pad_out got=%h exp=0", bus.pad_out); end
        bus.IR = IR_EX; #1;
        checks++; if (bus.pad_out !== 4'h0) begin failures++; $display("FAIL tlr_extest_pad_out got=%h exp=0", bus.pad_out); end
    endtask

    task automatic test_midshift_reset();
        bus.IR = IR_EX; bus.pad_in = 4'hA; bus.core_out = 4'h5;
        bus.tap_state = ST_CAP; step();
        for (int i = 0; i < 3; i++) begin
            bus.TDI = 1'b1; bus.tap_state = ST_SH; step();
        end
        checks++; if (bus.wrapper_tdo !== 1'b1 || bus.shift_cnt !== 8'd3) begin
            failures++; $display("FAIL midshift_pre got tdo=%b cnt=%0d exp tdo=1 cnt=3", bus.wrapper_tdo, bus.shift_cnt);
        end
        TRST = 1'b1; #1;
        checks++; if (bus.wrapper_tdo !== 1'b0) begin failures++; $display("FAIL midshift_tdo got=%b exp=0", bus.wrapper_tdo); end
        checks++; if (bus.shift_cnt !== 8'd0) begin failures++; $display("FAIL midshift_cnt got=%0d exp=0", bus.shift_cnt); end
        m_chain = 8'h00; m_upd = 8'h00; m_cnt = 0;
        @(negedge TCK);
        TRST = 1'b0;
        test_shift_byte("midshift_chain", 8'h00);
    endtask

    task automatic test_saturation();
        int exp;
        bus2.IR = IR_EX; bus2.tap_state = ST_CAP;
        @(posedge TCK); @(negedge TCK);
        checks++; if (bus2.shift_cnt !== 2'd0) begin failures++; $display("FAIL sat_cap got=%0d exp=0", bus2.shift_cnt); end
        for (int i = 0; i < 5; i++) begin
            bus2.tap_state = ST_SH; bus2.TDI = 1'b0;
            @(posedge TCK); @(negedge TCK);
            exp = (i + 1 > 3) ? 3 : i + 1;
            checks++;
            if (bus2.shift_cnt !== exp[1:0]) begin
                failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, bus2.shift_cnt, exp);
            end
        end
        bus2.tap_state = ST_IDLE;
    endtask

    initial begin
        bus.TDI = 1'b0; bus.tap_state = ST_IDLE; bus.IR = IR_EX;
        bus.pad_in = 4'h0; bus.core_out = 4'h0;
        bus2.TDI = 1'b0; bus2.tap_state = ST_IDLE; bus2.IR = IR_EX;
        bus2.pad_in = 4'h0; bus2.core_out = 4'h0;
        m_chain = 8'h00; m_upd = 8'h00; m_cnt = 0;
        test_reset();
        test_extest();
        test_intest();
        test_sample_preload();
        test_clamp();
        test_tlr();
        test_midshift_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
